// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - zero-crossing triggered writer for the double-buffered waveform RAM
//
// Purpose: waits for a positive-going zero crossing in the signed audio stream,
// then writes the next 2^ADDR_BITS samples (top 8 bits, offset binary) into the
// RAM half the display is not reading. Once the frame is complete it waits for
// display vblank and flips read_index so the display picks up the new frame.
//
// Ports:
//   clk                system clock
//   reset              asynchronous active-low reset
//   new_sample_ready   one-cycle strobe, new_sample_in valid
//   new_sample_in      two's-complement audio sample
//   wave_display_idle  display not scanning the wave region (vblank)
//   write_address      RAM write address {half, index}
//   write_enable       RAM write strobe
//   write_sample       offset-binary 8-bit sample
//   read_index         RAM half the display reads
module wave_capture #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  input  logic                    wave_display_idle,
  output logic [ADDR_BITS:0]      write_address,
  output logic                    write_enable,
  output logic [7:0]              write_sample,
  output logic                    read_index
);

  typedef enum logic [1:0] {
    ST_ARMED,
    ST_ACTIVE,
    ST_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] count_q, count_d;
  logic                 prev_neg_q, prev_neg_d;
  logic [ADDR_BITS:0]   addr_q, addr_d;
  logic                 we_q, we_d;
  logic [7:0]           sample_q, sample_d;
  logic                 ri_q, ri_d;
  logic                 crossing;
  logic                 sample_lsbs_unused;

  // Only the top byte is stored and only the sign is needed for crossing detection.
  assign sample_lsbs_unused = ^new_sample_in[SAMPLE_WIDTH-9:0];

  // Zero counts as non-negative, so -x followed by 0 is a crossing.
  assign crossing = new_sample_ready & prev_neg_q & ~new_sample_in[SAMPLE_WIDTH-1];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    sample_d   = sample_q;
    ri_d       = ri_q;
    we_d       = 1'b0;
    prev_neg_d = new_sample_ready ? new_sample_in[SAMPLE_WIDTH-1] : prev_neg_q;

    case (state_q)
      ST_ARMED: begin
        // The crossing sample itself is not written.
        if (crossing) begin
          count_d = '0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (new_sample_ready) begin
          we_d     = 1'b1;
          addr_d   = {~ri_q, count_q};
          // Flipping the sign bit converts two's complement to offset binary.
          sample_d = new_sample_in[SAMPLE_WIDTH-1 -: 8] ^ 8'h80;
          count_d  = count_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
          if (count_q == {ADDR_BITS{1'b1}}) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Leaving WAIT immediately guarantees one flip per frame even if idle stays high.
        if (wave_display_idle) begin
          ri_d    = ~ri_q;
          state_d = ST_ARMED;
        end
      end
      default: begin
        state_d = ST_ARMED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_ARMED;
      count_q    <= '0;
      prev_neg_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      sample_q   <= '0;
      ri_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      prev_neg_q <= prev_neg_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      sample_q   <= sample_d;
      ri_q       <= ri_d;
    end
  end

  assign write_address = addr_q;
  assign write_enable  = we_q;
  assign write_sample  = sample_q;
  assign read_index    = ri_q;

endmodule
